watch_time_keeper: RTL and testbench

//  Timekeeping core of the digital watch; consumes mode/set_pos/1 Hz/2 Hz outputs of the master select block.

---
 rtl/watch_pkg.sv | 29 ++
 rtl/bin2bcd_2digit.sv | 23 ++
 rtl/watch_time_keeper.sv | 119 +++++++++++
 tb/tb_watch_time_keeper.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared types and limits for the watch timekeeping core.
package watch_pkg;

    typedef enum logic {
        MODE_NORMAL  = 1'b0,
        MODE_SETTING = 1'b1
    } mode_e;

    typedef enum logic [2:0] {
        POSITION_NONE   = 3'b000,
        POSITION_SECOND = 3'b001,
        POSITION_MINUTE = 3'b010,
        POSITION_HOUR   = 3'b100
    } position_e;

    localparam int HOUR_W = 5;
    localparam int MIN_W  = 6;
    localparam int SEC_W  = 6;
    localparam int BCD_W  = 8;

    localparam logic [5:0] SEC_MAX = 6'd59;
    localparam logic [5:0] MIN_MAX = 6'd59;

    // Out-of-range values (only reachable by forcing) fall back to zero.
    function automatic logic [5:0] wrap_inc(input logic [5:0] value, input logic [5:0] max);
        return (value >= max) ? 6'd0 : value + 6'd1;
    endfunction

endpackage

// File: rtl/bin2bcd_2digit.sv
// Combinational 6-bit binary (0..63) to two-digit {tens,units} BCD converter.
module bin2bcd_2digit (
    input  logic [5:0] bin,
    output logic [7:0] bcd
);

    logic [5:0] rest;
    logic [2:0] tens;

    // NOTE: blocking assignments here, because each loop pass must see the previous pass's result.
    always_comb begin
        rest = bin;
        tens = 3'd0;
        for (int k = 0; k < 6; k++) begin
            if (rest >= 6'd10) begin
                rest = rest - 6'd10;
                tens = tens + 3'd1;
            end
        end
        bcd = {1'b0, tens, rest[3:0]};
    end

endmodule

// File: rtl/watch_time_keeper.sv
// HH:MM:SS timekeeper with setting mode, binary + BCD outputs and display blank flags.
// Define WATCH_BLINK_EN to make the selected field blink at 2 Hz through blank_out.
module watch_time_keeper
    import watch_pkg::*;
#(
    parameter int HOUR_MAX    = 23,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clk1hz_in,
    input  logic              clk2hz_in,
    input  logic              mode_in,
    input  logic [2:0]        set_pos_in,
    input  logic              sw_inc,
    output logic [HOUR_W-1:0] hour_out,
    output logic [MIN_W-1:0]  min_out,
    output logic [SEC_W-1:0]  sec_out,
    output logic [BCD_W-1:0]  hour_bcd,
    output logic [BCD_W-1:0]  min_bcd,
    output logic [BCD_W-1:0]  sec_bcd,
    output logic [2:0]        blank_out
);

    localparam int NUM_IN   = 3;
    localparam int IN_TICK  = 0;
    localparam int IN_BLINK = 1;
    localparam int IN_INC   = 2;

    localparam logic [5:0] HOUR_LIMIT = 6'(HOUR_MAX);

    logic [NUM_IN-1:0] async_in;
    logic [NUM_IN-1:0] sync_lvl;
    logic [NUM_IN-1:0] rise;

    assign async_in = {sw_inc, clk2hz_in, clk1hz_in};

    // prev_q resets to 0, so a level already high at reset release still yields one pulse.
    for (genvar i = 0; i < NUM_IN; i++) begin : g_sync
        logic [SYNC_STAGES-1:0] stages;
        logic                   prev_q;
        logic                   pulse_q;

        // NOTE: non-blocking assignments for all flops so the shift chain moves one stage per clock.
        always_ff @(posedge clk) begin
            if (!reset) begin
                stages  <= '0;
                prev_q  <= 1'b0;
                pulse_q <= 1'b0;
            end else begin
                stages  <= {stages[SYNC_STAGES-2:0], async_in[i]};
                prev_q  <= stages[SYNC_STAGES-1];
                pulse_q <= stages[SYNC_STAGES-1] & ~prev_q;
            end
        end

        assign sync_lvl[i] = stages[SYNC_STAGES-1];
        assign rise[i]     = pulse_q;
    end

    mode_e            mode;
    logic [5:0]       sec_inc;
    logic [5:0]       min_inc;
    logic [HOUR_W-1:0] hour_inc;

    assign mode     = mode_e'(mode_in);
    assign sec_inc  = wrap_inc(sec_out, SEC_MAX);
    assign min_inc  = wrap_inc(min_out, MIN_MAX);
    assign hour_inc = ({1'b0, hour_out} >= HOUR_LIMIT) ? '0 : hour_out + HOUR_W'(1);

    // The sampled mode picks exactly one pulse source; the other is dropped that cycle.
    always_ff @(posedge clk) begin
        if (!reset) begin
            hour_out <= '0;
            min_out  <= '0;
            sec_out  <= '0;
        end else if (mode == MODE_NORMAL) begin
            if (rise[IN_TICK]) begin
                sec_out <= sec_inc;
                if (sec_out >= SEC_MAX) begin
                    min_out <= min_inc;
                    if (min_out >= MIN_MAX) begin
                        hour_out <= hour_inc;
                    end
                end
            end
        end else if (rise[IN_INC]) begin
            case (set_pos_in)
                POSITION_HOUR:   hour_out <= hour_inc;
                POSITION_MINUTE: min_out  <= min_inc;
                POSITION_SECOND: sec_out  <= sec_inc;
                default:         ;
            endcase
        end
    end

    bin2bcd_2digit u_hour_bcd (.bin({1'b0, hour_out}), .bcd(hour_bcd));
    bin2bcd_2digit u_min_bcd  (.bin(min_out),          .bcd(min_bcd));
    bin2bcd_2digit u_sec_bcd  (.bin(sec_out),          .bcd(sec_bcd));

`ifdef WATCH_BLINK_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            blank_out <= 3'b000;
        end else begin
            blank_out <= set_pos_in & {3{mode_in & sync_lvl[IN_BLINK]}};
        end
    end

    logic unused_sync;
    assign unused_sync = ^{sync_lvl[IN_TICK], sync_lvl[IN_INC], rise[IN_BLINK]};
`else
    assign blank_out = 3'b000;

    logic unused_sync;
    assign unused_sync = ^{sync_lvl, rise[IN_BLINK]};
`endif

endmodule

// File: tb/tb_watch_time_keeper.sv
// Scoreboard bench for watch_time_keeper: driver pushes timed expectations, monitor compares.
module tb_watch_time_keeper;

    localparam int HOUR_MAX = 23;
    localparam int SYNC     = 2;
    localparam int LAT      = SYNC + 2;
`ifdef WATCH_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic       clk        = 1'b0;
    logic       reset      = 1'b0;
    logic       clk1hz_in  = 1'b0;
    logic       clk2hz_in  = 1'b0;
    logic       mode_in    = 1'b0;
    logic [2:0] set_pos_in = 3'b000;
    logic       sw_inc     = 1'b0;
    logic [4:0] hour_out;
    logic [5:0] min_out;
    logic [5:0] sec_out;
    logic [7:0] hour_bcd;
    logic [7:0] min_bcd;
    logic [7:0] sec_bcd;
    logic [2:0] blank_out;

    watch_time_keeper #(.HOUR_MAX(HOUR_MAX), .SYNC_STAGES(SYNC)) dut (
        .clk(clk), .reset(reset), .clk1hz_in(clk1hz_in), .clk2hz_in(clk2hz_in),
        .mode_in(mode_in), .set_pos_in(set_pos_in), .sw_inc(sw_inc),
        .hour_out(hour_out), .min_out(min_out), .sec_out(sec_out),
        .hour_bcd(hour_bcd), .min_bcd(min_bcd), .sec_bcd(sec_bcd), .blank_out(blank_out)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         due;
        int         h;
        int         m;
        int         s;
        logic [2:0] blank;
    } exp_t;

    exp_t  sb[$];
    string tag_q[$];

    int m_h = 0, m_m = 0, m_s = 0;
    int errors = 0, checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, expv);
        end
    endtask

    function automatic int to_bcd(input int v);
        return ((v / 10) << 4) | (v % 10);
    endfunction

    // Reference model: time as seconds of the day; setting adds one to a field modulo its range.
    function automatic void apply(input bit do_tick, input bit do_inc);
        int total;
        if (mode_in == 1'b0) begin
            if (do_tick) begin
                total = (m_h * 3600 + m_m * 60 + m_s + 1) % ((HOUR_MAX + 1) * 3600);
                m_h   = total / 3600;
                m_m   = (total / 60) % 60;
                m_s   = total % 60;
            end
        end else if (do_inc) begin
            case (set_pos_in)
                3'b100:  m_h = (m_h + 1) % (HOUR_MAX + 1);
                3'b010:  m_m = (m_m + 1) % 60;
                3'b001:  m_s = (m_s + 1) % 60;
                default: ;
            endcase
        end
    endfunction

    function automatic void push(input int due, input logic [2:0] blank, input string tag);
        sb.push_back('{due, m_h, m_m, m_s, blank});
        tag_q.push_back(tag);
    endfunction

    always @(negedge clk) begin : monitor
        exp_t  e;
        string t;
        while (sb.size() > 0 && sb[0].due <= cyc) begin
            e = sb.pop_front();
            t = tag_q.pop_front();
            check({t, "/time"}, 32'({hour_out, min_out, sec_out}),
                  32'({5'(e.h), 6'(e.m), 6'(e.s)}));
            check({t, "/bcd"}, 32'({hour_bcd, min_bcd, sec_bcd}),
                  32'({8'(to_bcd(e.h)), 8'(to_bcd(e.m)), 8'(to_bcd(e.s))}));
            check({t, "/blank"}, 32'(blank_out), 32'(e.blank));
        end
    end

    // One synchronised input rise; old value checked one cycle before the update is due.
    task automatic fire(input bit do_tick, input bit do_inc, input string tag);
        int k;
        k = cyc;
        push(k + LAT - 1, 3'b000, {tag, "_pre"});
        clk1hz_in = do_tick;
        sw_inc    = do_inc;
        apply(do_tick, do_inc);
        push(k + LAT, 3'b000, tag);
        repeat (3) @(negedge clk);
        clk1hz_in = 1'b0;
        sw_inc    = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    function automatic int field(input logic [2:0] pos);
        case (pos)
            3'b100:  return m_h;
            3'b010:  return m_m;
            default: return m_s;
        endcase
    endfunction

    task automatic set_field(input logic [2:0] pos, input int target, input string tag);
        mode_in    = 1'b1;
        set_pos_in = pos;
        for (int n = 0; n < 70 && field(pos) != target; n++) begin
            fire(1'b0, 1'b1, tag);
        end
    endtask

    task automatic blink_test();
        logic [2:0] prev_blank;
        logic [2:0] next_blank;
        mode_in    = 1'b1;
        set_pos_in = 3'b100;
        prev_blank = 3'b000;
        repeat (4) begin
            clk2hz_in  = ~clk2hz_in;
            next_blank = (BLINK && clk2hz_in) ? 3'b100 : 3'b000;
            push(cyc + 2, prev_blank, "blink_pre");
            push(cyc + 3, next_blank, "blink");
            prev_blank = next_blank;
            repeat (4) @(negedge clk);
        end
    endtask

    initial begin : driver
        // Reset with random activity on every input.
        reset = 1'b0;
        repeat (4) begin
            @(negedge clk);
            clk1hz_in  = 1'($urandom);
            clk2hz_in  = 1'($urandom);
            mode_in    = 1'($urandom);
            set_pos_in = 3'($urandom);
            sw_inc     = 1'($urandom);
        end
        @(negedge clk);
        clk1hz_in = 1'b0; clk2hz_in = 1'b0; mode_in = 1'b0; set_pos_in = 3'b000; sw_inc = 1'b0;
        push(cyc + 1, 3'b000, "reset");
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Button held through reset release gives exactly one increment.
        fire(1'b0, 1'b1, "pre_hold");
        mode_in = 1'b1; set_pos_in = 3'b001; sw_inc = 1'b1; reset = 1'b0;
        m_h = 0; m_m = 0; m_s = 0;
        repeat (3) @(negedge clk);
        push(cyc + 1, 3'b000, "rst_hold");
        @(negedge clk);
        reset = 1'b1;
        push(cyc + LAT - 1, 3'b000, "held_pre");
        m_s = 1;
        push(cyc + LAT, 3'b000, "held_one");
        repeat (LAT + 4) @(negedge clk);
        push(cyc + 1, 3'b000, "held_once");
        @(negedge clk);
        sw_inc = 1'b0;
        repeat (4) @(negedge clk);

        // Setting: minute wraps 59->0 without carry; ticks frozen.
        set_field(3'b100, 5, "set_hour");
        set_field(3'b010, 59, "set_min");
        fire(1'b0, 1'b1, "min_wrap");
        fire(1'b1, 1'b0, "tick_frozen");
        fire(1'b1, 1'b1, "both_set");

        // Ignored increments.
        set_pos_in = 3'b000; fire(1'b0, 1'b1, "pos_none");
        set_pos_in = 3'b011; fire(1'b0, 1'b1, "pos_011");
        set_pos_in = 3'b111; fire(1'b0, 1'b1, "pos_111");
        mode_in = 1'b0; set_pos_in = 3'b010; fire(1'b0, 1'b1, "inc_normal");

        // Carry 00:00:59 -> 00:01:00.
        set_field(3'b100, 0, "zero_hour");
        set_field(3'b010, 0, "zero_min");
        set_field(3'b001, 59, "sec59");
        mode_in = 1'b0;
        fire(1'b1, 1'b0, "carry");

        // Rollover 23:59:59 -> 00:00:00.
        set_field(3'b100, HOUR_MAX, "max_hour");
        set_field(3'b010, 59, "max_min");
        set_field(3'b001, 59, "max_sec");
        mode_in = 1'b0; set_pos_in = 3'b001;
        fire(1'b1, 1'b0, "rollover");
        fire(1'b1, 1'b1, "both_norm");

        blink_test();

        // Random mix of modes, positions and pulse sources.
        for (int n = 0; n < 60; n++) begin
            int kind;
            mode_in    = 1'($urandom);
            set_pos_in = 3'($urandom);
            kind       = $urandom_range(0, 2);
            fire(kind != 1, kind != 0, "random");
        end

        for (int n = 0; n < 20 && sb.size() > 0; n++) @(negedge clk);
        if (sb.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL drain: %0d expectations still pending, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
